// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and SPI mode decode for the SPI arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } arb_state_t;

  // Bit positions of CPOL and CPHA inside a 3-bit mode code
  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Codes 4..7 are not real SPI modes and fall back to mode 0
  function automatic spi_mode_t decode_mode(input logic [2:0] code);
    spi_mode_t m;
    m.cpol = 1'b0;
    m.cpha = 1'b0;
    if (!code[2]) begin
      m.cpol = code[MODE_CPOL_BIT];
      m.cpha = code[MODE_CPHA_BIT];
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: picks one requester, searching upward from ptr and wrapping.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic found;

  // First pass covers ptr..NREQ-1, second pass wraps around to 0..ptr-1
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI master among NREQ requesters, one byte per grant.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise fixed priority
// with requester 0 highest.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_mode,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NREQ-1:0]   cs_n
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(CLK_DIV);

  arb_state_t      state, next_state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   ptr;
  logic [DW-1:0]   div_cnt;
  logic            div_tick;
  logic [3:0]      edge_cnt;
  logic            leading_edge;
  logic            cpha;
  logic [7:0]      tx_shift;
  logic [7:0]      rx_shift;
  logic            cs_active;
  logic [2:0]      sel_mode;
  logic [7:0]      sel_data;
  spi_mode_t       mode_sel;

  spi_rr_arbiter #(
    .NREQ(NREQ),
    .IW  (IW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(grant)
  );

  assign div_tick     = (div_cnt == DW'(CLK_DIV - 1));
  assign leading_edge = ~edge_cnt[0];

  // Route the winning requester's mode and byte toward the latch in ARB
  always_comb begin
    sel_mode = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_mode = req_mode[i*3 +: 3];
        sel_data = req_data[i*8 +: 8];
      end
    end
    mode_sel = decode_mode(sel_mode);
  end

  // State register; reset aborts any transfer without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic plus state-decoded outputs
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = ARB;
      ARB:     next_state = (|grant) ? SETUP : IDLE;
      SETUP:   if (div_tick) next_state = SHIFT;
      SHIFT:   if (div_tick && (edge_cnt == 4'd15)) next_state = HOLD;
      HOLD:    if (div_tick) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    busy      = (state != IDLE);
    cs_active = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    cs_n      = cs_active ? ~gnt : '1;
    mosi      = cs_active ? tx_shift[7] : 1'b0;
    done      = (state == DONE) ? gnt : '0;
  end

  // Datapath: phase counter, SCLK edges, shift registers, grant and pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      gnt      <= '0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      cpha     <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      ptr      <= '0;
    end else begin
      if ((state != next_state) || div_tick) div_cnt <= '0;
      else                                   div_cnt <= div_cnt + 1'b1;
      case (state)
        ARB: begin
          if (|grant) begin
            gnt      <= grant;
            cpha     <= mode_sel.cpha;
            sclk     <= mode_sel.cpol;
            tx_shift <= sel_data;
            rx_shift <= '0;
            edge_cnt <= '0;
`ifdef SPI_ARB_RR_EN
            for (int i = 0; i < NREQ; i++) begin
              if (grant[i]) ptr <= (i == NREQ - 1) ? '0 : IW'(i + 1);
            end
`endif
          end
        end
        SHIFT: begin
          if (div_tick) begin
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (leading_edge ^ cpha)
              rx_shift <= {rx_shift[6:0], miso};
            else if (!cpha || (edge_cnt != 4'd0))
              tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        HOLD: begin
          if (div_tick) rx_data <= rx_shift;
        end
        DONE: begin
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: table-driven single transfers plus hand-written sequences
// for arbitration order, mid-transfer reset, dropped request and queued request.
module tb_spi_arbiter;

  localparam int NREQ    = 4;
  localparam int CLK_DIV = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [11:0]     req_mode;
  logic [31:0]     req_data;
  logic [3:0]      gnt;
  logic [3:0]      done;
  logic [7:0]      rx_data;
  logic            busy;
  logic            sclk;
  logic            mosi;
  logic            miso;
  logic [3:0]      cs_n;
  logic            loopback;
  logic            miso_tie;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [2:0] mode;
    logic [7:0] data;
    int         miso_sel;
    logic [7:0] exp_rx;
    logic       exp_cpol;
    logic       exp_cpha;
    logic [3:0] exp_csn;
  } vec_t;

  vec_t vecs[7];

  assign miso = loopback ? mosi : miso_tie;

  spi_arbiter #(
    .NREQ   (NREQ),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_mode(req_mode),
    .req_data(req_data),
    .gnt     (gnt),
    .done    (done),
    .rx_data (rx_data),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One full transfer for requester v.idx; cycle 1 is the ARB cycle
  task automatic apply_stimulus(input vec_t v, input int drop_at, input string tag);
    int         c;
    int         done_cnt;
    int         done_cycle;
    int         nbits;
    logic [7:0] mosi_cap;
    logic       prev_sclk;
    logic       prev_mosi;
    logic       viol;
    logic       timing_viol;
    logic [7:0] rx_at_done;
    logic [3:0] done_val;
    logic [3:0] exp_oh;
    exp_oh   = 4'b0001 << v.idx;
    loopback = (v.miso_sel == 0);
    miso_tie = (v.miso_sel == 1);
    req_mode[v.idx*3 +: 3] = v.mode;
    req_data[v.idx*8 +: 8] = v.data;
    req[v.idx] = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!busy && c < 20);
    check_output({tag, " busy_rise"}, 32'(busy), 32'd1);
    c = 1; done_cnt = 0; done_cycle = 0; nbits = 0; mosi_cap = '0;
    viol = 1'b0; timing_viol = 1'b0; rx_at_done = '0; done_val = '0;
    prev_sclk = sclk; prev_mosi = mosi;
    while (busy && c < 200 && done_cnt == 0) begin
      @(negedge clk);
      c++;
      if (c == 2) begin
        check_output({tag, " sclk_idle"}, 32'(sclk), 32'(v.exp_cpol));
        check_output({tag, " cs_n"}, 32'(cs_n), 32'(v.exp_csn));
        check_output({tag, " gnt"}, 32'(gnt), 32'(exp_oh));
      end
      if (c == drop_at) req[v.idx] = 1'b0;
      if (c > 2 && sclk !== prev_sclk) begin
        if ((sclk != v.exp_cpol) ^ v.exp_cpha) begin
          if (mosi !== prev_mosi) timing_viol = 1'b1;
          mosi_cap = {mosi_cap[6:0], mosi};
          nbits++;
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
      if ($countones(gnt) > 1 || $countones(~cs_n) > 1 || (cs_n == 4'hF && mosi !== 1'b0))
        viol = 1'b1;
      if (done != 4'b0) begin
        done_cnt++;
        done_cycle = c;
        done_val   = done;
        rx_at_done = rx_data;
      end
    end
    check_output({tag, " done_seen"}, 32'(done_cnt), 32'd1);
    check_output({tag, " latency"}, 32'(done_cycle), 32'd74);
    check_output({tag, " done_onehot"}, 32'(done_val), 32'(exp_oh));
    check_output({tag, " rx_data"}, 32'(rx_at_done), 32'(v.exp_rx));
    check_output({tag, " mosi_bits"}, 32'(nbits), 32'd8);
    check_output({tag, " mosi_byte"}, 32'(mosi_cap), 32'(v.data));
    check_output({tag, " mosi_timing"}, 32'(timing_viol), 32'd0);
    check_output({tag, " exclusivity"}, 32'(viol), 32'd0);
    req[v.idx] = 1'b0;
    @(negedge clk);
    check_output({tag, " done_pulse_end"}, 32'(done), 32'd0);
    check_output({tag, " idle_after"}, 32'(busy), 32'd0);
    check_output({tag, " rx_held"}, 32'(rx_data), 32'(v.exp_rx));
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         c;
    int         k;
    int         edges;
    logic       prev;
    logic       two_hot;
    logic       seen_done0;
    logic       finished;
    logic       done_flag;
    logic [3:0] after_gnt;
    logic [3:0] order[4];
    logic [3:0] exp_order[4];
    vec_t       vd;

    vecs[0] = '{0, 3'd0, 8'hA5, 0, 8'hA5, 1'b0, 1'b0, 4'b1110};
    vecs[1] = '{2, 3'd3, 8'h3C, 1, 8'hFF, 1'b1, 1'b1, 4'b1011};
    vecs[2] = '{1, 3'd1, 8'h5A, 0, 8'h5A, 1'b0, 1'b1, 4'b1101};
    vecs[3] = '{3, 3'd2, 8'hC3, 0, 8'hC3, 1'b1, 1'b0, 4'b0111};
    vecs[4] = '{1, 3'd5, 8'h81, 0, 8'h81, 1'b0, 1'b0, 4'b1101};
    vecs[5] = '{0, 3'd1, 8'hF0, 2, 8'h00, 1'b0, 1'b1, 4'b1110};
    vecs[6] = '{2, 3'd7, 8'h96, 0, 8'h96, 1'b0, 1'b0, 4'b1011};

    reset = 1'b0; req = '0; req_mode = '0; req_data = '0;
    loopback = 1'b1; miso_tie = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset gnt", 32'(gnt), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset rx_data", 32'(rx_data), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset sclk", 32'(sclk), 32'd0);
    check_output("reset mosi", 32'(mosi), 32'd0);
    check_output("reset cs_n", 32'(cs_n), 32'hF);
    reset = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 7; n++) apply_stimulus(vecs[n], 0, $sformatf("vec%0d", n));

    // Four transfers with every request held
    do_reset();
`ifdef SPI_ARB_RR_EN
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    loopback = 1'b1; req_mode = '0; req_data = 32'h11223344;
    for (int i = 0; i < 4; i++) order[i] = '0;
    req = 4'hF; k = 0; c = 0; two_hot = 1'b0;
    while (c < 600 && k < 4) begin
      @(negedge clk);
      c++;
      if ($countones(gnt) > 1) two_hot = 1'b1;
      if (done != 4'b0) begin
        order[k] = done;
        k++;
        if (k == 4) req = '0;
      end
    end
    req = '0;
    for (int i = 0; i < 4; i++)
      check_output($sformatf("order grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
    check_output("order two_hot", 32'(two_hot), 32'd0);
    @(negedge clk);
    check_output("order idle_after", 32'(busy), 32'd0);

    // Reset right after the 9th SCLK edge
    do_reset();
    loopback = 1'b1; req_mode[2:0] = 3'd0; req_data[7:0] = 8'hA5; req[0] = 1'b1;
    c = 0; edges = 0; prev = sclk; done_flag = 1'b0;
    while (c < 200 && edges < 9) begin
      @(negedge clk);
      c++;
      if (c > 3 && sclk !== prev) edges++;
      prev = sclk;
      if (done != 4'b0) done_flag = 1'b1;
    end
    check_output("abort edge_count", 32'(edges), 32'd9);
    reset = 1'b0; req = '0;
    @(posedge clk);
    #1;
    check_output("abort cs_n", 32'(cs_n), 32'hF);
    check_output("abort sclk", 32'(sclk), 32'd0);
    check_output("abort mosi", 32'(mosi), 32'd0);
    check_output("abort busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (done != 4'b0) done_flag = 1'b1;
    end
    check_output("abort no_done", 32'(done_flag), 32'd0);
    check_output("abort rx_cleared", 32'(rx_data), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    vd = '{1, 3'd0, 8'h69, 0, 8'h69, 1'b0, 1'b0, 4'b1101};
    apply_stimulus(vd, 0, "post_abort");

    // Request 1 dropped once shifting has started
    vd = '{1, 3'd1, 8'h42, 0, 8'h42, 1'b0, 1'b1, 4'b1101};
    apply_stimulus(vd, 7, "dropped_req");

    // Requester 3 arrives during requester 0's transfer
    loopback = 1'b1; req_mode = '0; req_data = 32'h7700_00E1;
    req[0] = 1'b1; c = 0; two_hot = 1'b0; seen_done0 = 1'b0; finished = 1'b0;
    after_gnt = '0;
    while (c < 400 && !finished) begin
      @(negedge clk);
      c++;
      if (c == 20) req[3] = 1'b1;
      if ($countones(gnt) > 1) two_hot = 1'b1;
      if (done[0]) begin
        req[0] = 1'b0;
        seen_done0 = 1'b1;
      end else if (seen_done0 && gnt != 4'b0 && after_gnt == 4'b0) begin
        after_gnt = gnt;
      end
      if (done[3]) begin
        req[3] = 1'b0;
        finished = 1'b1;
      end
    end
    req = '0;
    check_output("queued done0_seen", 32'(seen_done0), 32'd1);
    check_output("queued next_grant", 32'(after_gnt), 32'b1000);
    check_output("queued done3_seen", 32'(finished), 32'd1);
    check_output("queued two_hot", 32'(two_hot), 32'd0);
    check_output("queued rx_data", 32'(rx_data), 32'h77);
    @(negedge clk);
    check_output("queued idle_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
